gen_inject: RTL
===============

Name: gen_inject

Overview:
- Sits directly downstream of the test-signal generator, in the adc_clk domain.
- Merges generator samples (gen_data) with live ADC samples ahead of the receiver DDC input.
- Selects ADC-only, generator-only or ADC+generator sum.
- Every change of source is a linear gain ramp, so no step discontinuities reach the DDCs; the sum saturates and overflow events are counted.

Parameters:
- W, 18, sample width of all data ports (signed).
- RAMP_LOG2, 10, ramp length is 2^RAMP_LOG2 cycles; full-scale gain FULL = 2^RAMP_LOG2.

Ports:
- adc_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- adc_data  in  W  signed ADC sample, valid every cycle.
- gen_data  in  W  signed generator sample, valid every cycle.
- mode  in  2  requested source: 0 = ADC, 1 = GEN, 2 = SUM, 3 = treated as 0.
- mode_stb  in  1  one-cycle pulse, already synchronised to adc_clk; samples mode.
- ovfl_clr  in  1  one-cycle pulse; clears ovfl_cnt.
- rx_data  out  W  signed merged sample.
- ramp_busy  out  1  high while in state UP or DOWN.
- ovfl_cnt  out  16  saturation event counter.

Behaviour:
Reset (async) values:
- state = OFF, cur_mode = ADC, pend_mode = ADC, g = 0.
- Pipeline registers = 0, rx_data = 0, ramp_busy = 0, ovfl_cnt = 0.

"Gen-involved" means mode GEN or SUM.

Gain FSM, all transitions on the adc_clk edge:
- OFF (g = 0)
  - mode_stb with gen-involved mode M: cur_mode <= M, pend_mode <= M, go to UP.
  - mode_stb with ADC: ignored.
- UP
  - g <= g + 1 each cycle; when g reaches FULL, go to ON.
  - mode_stb with M != cur_mode: pend_mode <= M, go to DOWN; g descends from its current value with no jump.
  - mode_stb with M == cur_mode: ignored.
- ON (g = FULL)
  - mode_stb with M != cur_mode: pend_mode <= M, go to DOWN.
- DOWN
  - g <= g - 1 each cycle.
  - mode_stb: pend_mode <= M (last strobe wins); ramp is not interrupted.
  - When g reaches 0: cur_mode <= pend_mode; go to UP if pend_mode is gen-involved, else OFF.
- g is RAMP_LOG2+1 bits unsigned; it never leaves [0, FULL].

Weights, derived from cur_mode and g:
- wg = 0 if cur_mode = ADC, else g.
- wa = FULL − g if cur_mode = GEN, else FULL.
- GEN is therefore a crossfade; SUM fades in the generator on top of the ADC signal.

Datapath, latency exactly 2 cycles from inputs to rx_data:
- Stage 1 registers:
  - ta = (adc_data·wa + 2^(RAMP_LOG2−1)) >>> RAMP_LOG2
  - tg = (gen_data·wg + 2^(RAMP_LOG2−1)) >>> RAMP_LOG2
  - Arithmetic shift; products are full width with no intermediate truncation.
  - A weight of FULL returns the input exactly; a weight of 0 returns 0.
  - wa and wg are taken from the g and cur_mode values current in the same cycle as the input sample.
- Stage 2:
  - s = ta + tg, computed at W+1 bits.
  - rx_data <= s clamped to [−2^(W−1), 2^(W−1)−1].
  - sat = 1 when clamping occurred.
- ovfl_cnt:
  - Increments on each sat cycle and holds at 65535.
  - ovfl_clr clears it; ovfl_clr and sat in the same cycle leave 0 (clear wins).

Boundaries:
- Reset mid-ramp returns immediately to OFF/ADC with g = 0; rx_data = 0 until the pipeline refills.
- mode_stb in the same cycle that UP reaches FULL: the transition to DOWN is taken, with g = FULL.
- mode_stb in the same cycle that DOWN reaches 0: the new strobe overwrites pend_mode before it is loaded.

Test Plan:
1. After reset, drive adc_data = 1000, gen_data = 5000, no strobe → rx_data = 0 for 2 cycles, then 1000; ramp_busy = 0; ovfl_cnt = 0.
2. RAMP_LOG2 = 4, adc_data = 1600, gen_data = 3200, mode_stb with GEN → ramp_busy high for 16 cycles; at g = 8 rx_data = 2400; final rx_data = 3200, 2 cycles after g = 16; state ON.
3. mode SUM, adc_data = 100000, gen_data = 100000, ramp complete → rx_data = 131071 and ovfl_cnt increments by 1 per cycle; with inputs −100000 → rx_data = −131072.
4. RAMP_LOG2 = 4, GEN ramp, mode_stb with SUM at g = 6 → g descends 6..0, cur_mode becomes SUM, ramps 0..16; rx_data never steps by more than one gain step.
5. In ON, mode_stb ADC then mode_stb GEN during DOWN → after reaching 0, cur_mode = GEN and ramps up again (last strobe wins).
6. Reset asserted at g = 9 during UP → state OFF, g = 0, ramp_busy = 0 asynchronously. Separately, ovfl_clr coincident with sat → ovfl_cnt = 0.

Source files
------------

// File: rtl/gen_inject.sv
// gen_inject: merges generator and ADC samples ahead of the DDC input.
// Every change of source is a linear gain ramp; the sum saturates and
// saturation events are counted.
module gen_inject #(
  parameter int unsigned W         = 18,
  parameter int unsigned RAMP_LOG2 = 10
) (
  input  logic                adc_clk,
  input  logic                reset,
  input  logic signed [W-1:0] adc_data,
  input  logic signed [W-1:0] gen_data,
  input  logic [1:0]          mode,
  input  logic                mode_stb,
  input  logic                ovfl_clr,
  output logic signed [W-1:0] rx_data,
  output logic                ramp_busy,
  output logic [15:0]         ovfl_cnt
);

  localparam int unsigned GW = RAMP_LOG2 + 1;  // gain width, holds 0..FULL
  localparam int unsigned PW = W + GW + 1;     // signed product width
  localparam int unsigned SW = W + 1;          // sum width

  localparam logic [GW-1:0]        FULL   = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic signed [PW-1:0] HALF   = PW'(2 ** (RAMP_LOG2 - 1));
  localparam logic signed [W-1:0]  RX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  RX_MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] M_ADC = 2'd0;
  localparam logic [1:0] M_GEN = 2'd1;
  localparam logic [1:0] M_SUM = 2'd2;

  typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

  state_t      state, state_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [1:0]  cur_mode, cur_mode_nxt;
  logic [1:0]  pend_mode, pend_mode_nxt;

  logic [1:0]  req_c;
  logic        req_gen_c;
  logic        busy_nxt;
  logic [GW-1:0] wa_c, wg_c;

  logic signed [PW-1:0] pa_c, pg_c;
  logic signed [W-1:0]  ta, tg;
  logic signed [SW-1:0] s_c;
  logic                 sat_hi_c, sat_lo_c, sat_c;

  // Normalise the requested mode: code 3 behaves as ADC.
  always_comb begin
    req_c     = (mode == 2'd3) ? M_ADC : mode;
    req_gen_c = (req_c == M_GEN) || (req_c == M_SUM);
  end

  // FSM state register together with the gain and mode context it owns.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state     <= S_OFF;
      g         <= '0;
      cur_mode  <= M_ADC;
      pend_mode <= M_ADC;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      cur_mode  <= cur_mode_nxt;
      pend_mode <= pend_mode_nxt;
    end
  end

  // Next-state logic: ramps are never interrupted mid-way down, only redirected.
  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    cur_mode_nxt  = cur_mode;
    pend_mode_nxt = pend_mode;
    unique case (state)
      S_OFF: begin
        if (mode_stb && req_gen_c) begin
          cur_mode_nxt  = req_c;
          pend_mode_nxt = req_c;
          state_nxt     = S_UP;
        end
      end
      S_UP: begin
        g_nxt = (g == FULL) ? FULL : g + GW'(1);
        if (mode_stb && (req_c != cur_mode)) begin
          pend_mode_nxt = req_c;
          state_nxt     = S_DOWN;
        end else if (g_nxt == FULL) begin
          state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (mode_stb && (req_c != cur_mode)) begin
          pend_mode_nxt = req_c;
          state_nxt     = S_DOWN;
        end
      end
      S_DOWN: begin
        g_nxt = (g == '0) ? '0 : g - GW'(1);
        if (mode_stb) begin
          pend_mode_nxt = req_c;
        end
        if (g_nxt == '0) begin
          cur_mode_nxt = pend_mode_nxt;
          state_nxt    = ((pend_mode_nxt == M_GEN) || (pend_mode_nxt == M_SUM)) ? S_UP : S_OFF;
        end
      end
      default: begin
        state_nxt = S_OFF;
        g_nxt     = '0;
      end
    endcase
  end

  // Output logic: busy flag for the next cycle and the per-source weights.
  always_comb begin
    busy_nxt = (state_nxt == S_UP) || (state_nxt == S_DOWN);
    wg_c     = (cur_mode == M_ADC) ? '0 : g;
    wa_c     = (cur_mode == M_GEN) ? (FULL - g) : FULL;
  end

  // Registered busy flag.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) ramp_busy <= 1'b0;
    else       ramp_busy <= busy_nxt;
  end

  // Full-width signed products of sample and gain.
  always_comb begin
    pa_c = $signed(PW'(adc_data)) * $signed(PW'(wa_c));
    pg_c = $signed(PW'(gen_data)) * $signed(PW'(wg_c));
  end

  // Stage 1: round-half-up and scale back by FULL.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      ta <= '0;
      tg <= '0;
    end else begin
      ta <= W'((pa_c + HALF) >>> RAMP_LOG2);
      tg <= W'((pg_c + HALF) >>> RAMP_LOG2);
    end
  end

  // Sum at one extra bit and detect clamping.
  always_comb begin
    s_c      = SW'(ta) + SW'(tg);
    sat_hi_c = s_c > SW'(RX_MAX);
    sat_lo_c = s_c < SW'(RX_MIN);
    sat_c    = sat_hi_c || sat_lo_c;
  end

  // Stage 2: clamped output sample.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset)         rx_data <= '0;
    else if (sat_hi_c) rx_data <= RX_MAX;
    else if (sat_lo_c) rx_data <= RX_MIN;
    else               rx_data <= W'(s_c);
  end

  // Saturating overflow counter; a clear beats a coincident event.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset)                             ovfl_cnt <= '0;
    else if (ovfl_clr)                     ovfl_cnt <= '0;
    else if (sat_c && (ovfl_cnt != 16'hFFFF)) ovfl_cnt <= ovfl_cnt + 16'd1;
  end

endmodule
